// File: rtl/tt_um_brs_peak_tracker.sv
// Streaming byte peak tracker: running max/min/count of samples strobed on uio_in[0].
// Optional PEAK_INDEX_EN macro adds a peak_idx register shown on sel=11 instead of range.
module tt_um_brs_peak_tracker #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    TRACK = 2'b01
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] vs_q, vs_d, cs_q, cs_d;
  logic                   prev_q, prev_d;
  logic [7:0]             max_q, max_d, min_q, min_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                   new_max_q, new_max_d, new_min_q, new_min_d;
  logic                   strobe, clr, cnt_sat;
  logic [7:0]             range_val;
`ifdef PEAK_INDEX_EN
  logic [7:0]             pidx_q, pidx_d;
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:4]};

  // The valid edge detector runs off the synchronised level, so a held valid yields one sample.
  assign strobe  = vs_q[SYNC_STAGES-1] & ~prev_q;
  assign clr     = cs_q[SYNC_STAGES-1];
  assign cnt_sat = &cnt_q;
  assign cnt_inc = cnt_sat ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      vs_q      <= '0;
      cs_q      <= '0;
      prev_q    <= 1'b0;
      max_q     <= 8'h00;
      min_q     <= 8'hFF;
      cnt_q     <= '0;
      new_max_q <= 1'b0;
      new_min_q <= 1'b0;
`ifdef PEAK_INDEX_EN
      pidx_q    <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      vs_q      <= vs_d;
      cs_q      <= cs_d;
      prev_q    <= prev_d;
      max_q     <= max_d;
      min_q     <= min_d;
      cnt_q     <= cnt_d;
      new_max_q <= new_max_d;
      new_min_q <= new_min_d;
`ifdef PEAK_INDEX_EN
      pidx_q    <= pidx_d;
`endif
    end
  end

  always_comb begin
    vs_d      = {vs_q[SYNC_STAGES-2:0], uio_in[0]};
    cs_d      = {cs_q[SYNC_STAGES-2:0], uio_in[1]};
    prev_d    = vs_q[SYNC_STAGES-1];
    state_d   = (state_q == TRACK) ? TRACK : EMPTY;
    max_d     = max_q;
    min_d     = min_q;
    cnt_d     = cnt_q;
    new_max_d = 1'b0;
    new_min_d = 1'b0;
`ifdef PEAK_INDEX_EN
    pidx_d    = pidx_q;
`endif
    if (clr) begin
      // Clear outranks a coincident strobe; that sample is dropped.
      state_d = EMPTY;
      max_d   = 8'h00;
      min_d   = 8'hFF;
      cnt_d   = '0;
`ifdef PEAK_INDEX_EN
      pidx_d  = 8'h00;
`endif
    end else if (strobe) begin
      case (state_q)
        TRACK: begin
          cnt_d = cnt_inc;
          if (ui_in > max_q) begin
            max_d     = ui_in;
            new_max_d = 1'b1;
`ifdef PEAK_INDEX_EN
            pidx_d    = 8'(cnt_inc);
`endif
          end
          if (ui_in < min_q) begin
            min_d     = ui_in;
            new_min_d = 1'b1;
          end
        end
        default: begin
          state_d   = TRACK;
          max_d     = ui_in;
          min_d     = ui_in;
          cnt_d     = CNT_W'(1);
          new_max_d = 1'b1;
          new_min_d = 1'b1;
`ifdef PEAK_INDEX_EN
          pidx_d    = 8'h01;
`endif
        end
      endcase
    end
  end

  always_comb begin
    range_val = (state_q == TRACK) ? (max_q - min_q) : 8'h00;
    case (uio_in[3:2])
      2'b00:   uo_out = max_q;
      2'b01:   uo_out = min_q;
      2'b10:   uo_out = 8'(cnt_q);
`ifdef PEAK_INDEX_EN
      default: uo_out = pidx_q;
`else
      default: uo_out = range_val;
`endif
    endcase
    uio_out = {cnt_sat, new_min_q, new_max_q, (state_q == TRACK), 4'b0000};
    uio_oe  = 8'hF0;
  end

endmodule

// File: tb/tb_tt_um_brs_peak_tracker.sv
// Directed bench for tt_um_brs_peak_tracker: a CNT_W=8 and a CNT_W=3 instance share stimulus.
module tb_tt_um_brs_peak_tracker;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic [7:0] uo3, uio_out3, uio_oe3;

  int checks;
  int errors;

  typedef struct {
    logic [7:0] smp;
    logic [7:0] mx;
    logic [7:0] mn;
    logic [7:0] cnt;
    logic       nm;
    logic       nn;
  } vec_t;

  vec_t vecs[5];

  tt_um_brs_peak_tracker dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  tt_um_brs_peak_tracker #(.SYNC_STAGES(2), .CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo3), .uio_out(uio_out3), .uio_oe(uio_oe3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [1:0] s, output logic [7:0] v8, output logic [7:0] v3);
    uio_in[3:2] = s;
    #1;
    v8 = uo_out;
    v3 = uo3;
  endtask

  // One sample: valid rise, update lands on the third edge, pulse sampled then and one edge later.
  task automatic send(input logic [7:0] v, output logic nm, output logic nn,
                      output logic nm_after, output logic nn_after);
    ui_in      = v;
    uio_in[0]  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nm = uio_out[5];
    nn = uio_out[6];
    @(posedge clk);
    #1;
    nm_after = uio_out[5];
    nn_after = uio_out[6];
    uio_in[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    uio_in[1] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    uio_in[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] a, b;
    logic nm, nn, nma, nna;
    checks = 0;
    errors = 0;
    vecs[0] = '{smp: 8'h40, mx: 8'h40, mn: 8'h40, cnt: 8'd1, nm: 1'b1, nn: 1'b1};
    vecs[1] = '{smp: 8'h10, mx: 8'h40, mn: 8'h10, cnt: 8'd2, nm: 1'b0, nn: 1'b1};
    vecs[2] = '{smp: 8'h90, mx: 8'h90, mn: 8'h10, cnt: 8'd3, nm: 1'b1, nn: 1'b0};
    vecs[3] = '{smp: 8'h90, mx: 8'h90, mn: 8'h10, cnt: 8'd4, nm: 1'b0, nn: 1'b0};
    vecs[4] = '{smp: 8'h20, mx: 8'h90, mn: 8'h10, cnt: 8'd5, nm: 1'b0, nn: 1'b0};

    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // reset state
    rd(2'b00, a, b); chk("rst_max", a, 8'h00);
    rd(2'b01, a, b); chk("rst_min", a, 8'hFF);
    rd(2'b10, a, b); chk("rst_cnt", a, 8'h00);
    rd(2'b11, a, b); chk("rst_sel11", a, 8'h00);
    chk("rst_uio_out", uio_out, 8'h00);
    chk("rst_uio_oe", uio_oe, 8'hF0);

    // table-driven stream
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].smp, nm, nn, nma, nna);
      chk($sformatf("v%0d_new_max", i), {7'b0, nm}, {7'b0, vecs[i].nm});
      chk($sformatf("v%0d_new_min", i), {7'b0, nn}, {7'b0, vecs[i].nn});
      chk($sformatf("v%0d_pulse_end", i), {6'b0, nma, nna}, 8'h00);
      rd(2'b00, a, b); chk($sformatf("v%0d_max", i), a, vecs[i].mx);
      rd(2'b01, a, b); chk($sformatf("v%0d_min", i), a, vecs[i].mn);
      rd(2'b10, a, b); chk($sformatf("v%0d_cnt", i), a, vecs[i].cnt);
      chk($sformatf("v%0d_has_data", i), {7'b0, uio_out[4]}, 8'h01);
    end
    rd(2'b11, a, b);
`ifdef PEAK_INDEX_EN
    chk("stream_peak_idx", a, 8'd3);
`else
    chk("stream_range", a, 8'h80);
`endif

    // clear in the same cycle as a strobe of 55
    ui_in     = 8'h55;
    uio_in[1] = 1'b1;
    uio_in[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("clr_has_data", {7'b0, uio_out[4]}, 8'h00);
    rd(2'b10, a, b); chk("clr_cnt", a, 8'h00);
    rd(2'b00, a, b); chk("clr_max", a, 8'h00);
    // drop and re-raise valid while clear is still held
    uio_in[0] = 1'b0;
    repeat (4) @(posedge clk);
    uio_in[0] = 1'b1;
    repeat (4) @(posedge clk);
    uio_in[1] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rd(2'b10, a, b); chk("clr_edge_ignored", a, 8'h00);
    uio_in[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send(8'h33, nm, nn, nma, nna);
    rd(2'b00, a, b); chk("post_clr_max", a, 8'h33);
    rd(2'b01, a, b); chk("post_clr_min", a, 8'h33);
    rd(2'b10, a, b); chk("post_clr_cnt", a, 8'h01);

    // async reset mid-cycle
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    rd(2'b00, a, b); chk("arst_max", a, 8'h00);
    rd(2'b01, a, b); chk("arst_min", a, 8'hFF);
    chk("arst_uio_out", uio_out, 8'h00);
    #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // valid held high: single sample, visible on the third edge after the rise
    ui_in     = 8'h07;
    uio_in[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rd(2'b10, a, b); chk("hold_cnt_edge2", a, 8'h00);
    @(posedge clk);
    #1;
    rd(2'b10, a, b); chk("hold_cnt_edge3", a, 8'h01);
    rd(2'b00, a, b); chk("hold_max", a, 8'h07);
    repeat (17) @(posedge clk);
    uio_in[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rd(2'b10, a, b); chk("hold_cnt_final", a, 8'h01);

    // saturation on the CNT_W=3 instance
    do_clear();
    for (int i = 1; i <= 9; i++) begin
      send((i == 9) ? 8'hFF : 8'(i), nm, nn, nma, nna);
      if (i == 6) chk("sat3_before", {7'b0, uio_out3[7]}, 8'h00);
      if (i == 7) begin
        chk("sat3_at7", {7'b0, uio_out3[7]}, 8'h01);
        rd(2'b10, a, b); chk("cnt3_at7", b, 8'd7);
      end
    end
    rd(2'b10, a, b);
    chk("cnt3_final", b, 8'd7);
    chk("cnt8_final", a, 8'd9);
    chk("sat3_final", {7'b0, uio_out3[7]}, 8'h01);
    chk("sat8_final", {7'b0, uio_out[7]}, 8'h00);
    rd(2'b00, a, b);
    chk("max3_after_sat", b, 8'hFF);
    chk("max8_final", a, 8'hFF);

    // peak index vs range
    do_clear();
    send(8'd5, nm, nn, nma, nna);
    send(8'd9, nm, nn, nma, nna);
    send(8'd9, nm, nn, nma, nna);
    send(8'd3, nm, nn, nma, nna);
    send(8'd12, nm, nn, nma, nna);
    rd(2'b11, a, b);
`ifdef PEAK_INDEX_EN
    chk("peak_idx", a, 8'd5);
`else
    chk("range_5_12", a, 8'd9);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
